// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame-length floor,
// parity-type encoding and the per-frame configuration captured at start.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } parity_type_t;

  localparam int MIN_LEN = 5;

  typedef struct packed {
    logic         par_en;
    parity_type_t parity_type;
    logic         two_stop;
    logic [3:0]   len;
  } uart_cfg_t;

  function automatic logic [3:0] clamp_len(input logic [3:0] len,
                                           input logic [3:0] max_len);
    if (len < 4'(MIN_LEN)) return 4'(MIN_LEN);
    if (len > max_len)     return max_len;
    return len;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line conditioning for the receiver: 2-flop synchroniser, a two-deep
// history of the synchronised line and a 3-sample majority vote at mid-bit.
module uart_rx_sampler #(
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = $clog2(OVERSAMPLE)
) (
  input  logic             clk_16bd,
  input  logic             rst,
  input  logic             Rx,
  input  logic [CNT_W-1:0] cnt,
  output logic             rx_s,
  output logic             bit_val,
  output logic             bit_strobe
);

  logic [1:0] sync_q;
  logic [1:0] hist_q;

  // Line idles high, so the synchroniser and history reset to 1 to avoid
  // a phantom start edge straight out of reset.
  always_ff @(posedge clk_16bd) begin
    if (rst) begin
      sync_q <= 2'b11;
      hist_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], Rx};
      hist_q <= {hist_q[0], sync_q[1]};
    end
  end

  assign rx_s = sync_q[1];

  // At count OVERSAMPLE/2+1, hist_q holds the samples from the two
  // preceding counts and rx_s is the third.
  assign bit_strobe = (cnt == CNT_W'(OVERSAMPLE / 2 + 1));
  assign bit_val    = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) |
                      (hist_q[0] & rx_s);

endmodule

// File: rtl/uart_rx_engine.sv
// Parametrised UART receive engine: frame FSM, data shift register,
// parity/framing checks and a valid/ready output register with overrun.
module uart_rx_engine
  import uart_pkg::*;
#(
  parameter int DATA_MAX   = 9,
  parameter int OVERSAMPLE = 16
) (
  input  logic                clk_16bd,
  input  logic                rst,
  input  logic                Rx,
  input  logic                parity,
  input  logic                parity_type,
  input  logic                stop_bits,
  input  logic [3:0]          frame_length,
  output logic [DATA_MAX-1:0] frame,
  output logic                frame_valid,
  input  logic                frame_ready,
  output logic                parity_err,
  output logic                frame_err,
  output logic                overrun
);

  localparam int               CNT_W    = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

  uart_rx_state_t      state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                armed_q, armed_d;
  logic [3:0]          bit_idx_q, bit_idx_d;
  logic                stop_idx_q, stop_idx_d;
  logic [DATA_MAX-1:0] shift_q, shift_d;
  logic                perr_q, perr_d;
  logic                ferr_q, ferr_d;
  uart_cfg_t           cfg_q, cfg_d;

  logic [DATA_MAX-1:0] frame_q, frame_d;
  logic                valid_q, valid_d;
  logic                perr_out_q, perr_out_d;
  logic                ferr_out_q, ferr_out_d;
  logic                overrun_q, overrun_d;

  logic rx_s, bit_val, bit_strobe, wrap, deliver, accept;

  uart_rx_sampler #(
    .OVERSAMPLE(OVERSAMPLE),
    .CNT_W     (CNT_W)
  ) u_sampler (
    .clk_16bd  (clk_16bd),
    .rst       (rst),
    .Rx        (Rx),
    .cnt       (cnt_q),
    .rx_s      (rx_s),
    .bit_val   (bit_val),
    .bit_strobe(bit_strobe)
  );

  assign wrap   = (cnt_q == CNT_LAST);
  assign accept = valid_q & frame_ready;

  always_comb begin
    // NOTE: every _d takes its hold value first, so no path through this
    // block leaves a signal unassigned and no latch is inferred.
    state_d    = state_q;
    cnt_d      = cnt_q;
    armed_d    = armed_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    cfg_d      = cfg_q;
    deliver    = 1'b0;

    if (state_q != IDLE) cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);

    unique case (state_q)
      IDLE: begin
        cnt_d   = '0;
        // Arming needs one high tick, so a line held low cannot relock.
        armed_d = armed_q | rx_s;
        if (armed_q && !rx_s) begin
          state_d           = START;
          armed_d           = 1'b0;
          bit_idx_d         = '0;
          stop_idx_d        = 1'b0;
          shift_d           = '0;
          perr_d            = 1'b0;
          ferr_d            = 1'b0;
          cfg_d.par_en      = parity;
          cfg_d.parity_type = parity_type_t'(parity_type);
          cfg_d.two_stop    = stop_bits;
          cfg_d.len         = clamp_len(frame_length, 4'(DATA_MAX));
        end
      end
      START: begin
        if (bit_strobe && bit_val) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (wrap) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (bit_strobe) shift_d[bit_idx_q] = bit_val;
        if (wrap) begin
          if (bit_idx_q == cfg_q.len - 4'd1) state_d = cfg_q.par_en ? PARITY : STOP;
          else                               bit_idx_d = bit_idx_q + 4'd1;
        end
      end
      PARITY: begin
        if (bit_strobe)
          perr_d = ^shift_q ^ bit_val ^ (cfg_q.parity_type == PAR_ODD);
        if (wrap) state_d = STOP;
      end
      STOP: begin
        if (bit_strobe) begin
          if (!bit_val) ferr_d = 1'b1;
          // Leaving at mid-stop lets a start edge in the second half be caught.
          if (stop_idx_q == cfg_q.two_stop) begin
            deliver = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else if (wrap) begin
          stop_idx_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    frame_d    = frame_q;
    valid_d    = valid_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    overrun_d  = 1'b0;
    if (deliver && (!valid_q || accept)) begin
      frame_d    = shift_q;
      valid_d    = 1'b1;
      perr_out_d = perr_q;
      ferr_out_d = ferr_d;
    end else if (deliver) begin
      overrun_d = 1'b1;
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // register samples the pre-edge value of its neighbours.
  always_ff @(posedge clk_16bd) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      armed_q    <= 1'b0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      cfg_q      <= '0;
      frame_q    <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      armed_q    <= armed_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      cfg_q      <= cfg_d;
      frame_q    <= frame_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      overrun_q  <= overrun_d;
    end
  end

  assign frame       = frame_q;
  assign frame_valid = valid_q;
  assign parity_err  = perr_out_q;
  assign frame_err   = ferr_out_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine: stimulus pushes expected frames into a
// scoreboard queue, a monitor pops and compares on every valid/ready handshake.
module tb_uart_rx_engine;

  localparam int OS = 16;
  localparam int DM = 9;

  logic          clk_16bd = 1'b0;
  logic          rst;
  logic          Rx;
  logic          parity, parity_type, stop_bits;
  logic [3:0]    frame_length;
  logic [DM-1:0] frame;
  logic          frame_valid, frame_ready;
  logic          parity_err, frame_err, overrun;

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   ovr_cnt  = 0;

  uart_rx_engine #(.DATA_MAX(DM), .OVERSAMPLE(OS)) dut (
    .clk_16bd    (clk_16bd),
    .rst         (rst),
    .Rx          (Rx),
    .parity      (parity),
    .parity_type (parity_type),
    .stop_bits   (stop_bits),
    .frame_length(frame_length),
    .frame       (frame),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun     (overrun)
  );

  always #5 clk_16bd = ~clk_16bd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [8:0] d, input logic pe, input logic fe);
    exp_t e;
    e.data = d;
    e.perr = pe;
    e.ferr = fe;
    sb.push_back(e);
  endtask

  task automatic set_cfg(input logic p, input logic pt, input logic two, input logic [3:0] fl);
    parity       = p;
    parity_type  = pt;
    stop_bits    = two;
    frame_length = fl;
  endtask

  task automatic idle(input int n);
    Rx = 1'b1;
    repeat (n) @(negedge clk_16bd);
  endtask

  // A glitched bit is inverted for the single tick that feeds the centre vote sample.
  task automatic send_bit(input logic b, input bit glitch);
    Rx = b;
    if (glitch) begin
      repeat (9) @(negedge clk_16bd);
      Rx = ~b;
      @(negedge clk_16bd);
      Rx = b;
      repeat (OS - 10) @(negedge clk_16bd);
    end else begin
      repeat (OS) @(negedge clk_16bd);
    end
  endtask

  task automatic send_frame(input logic [8:0] data, input int len, input bit par_en,
                            input logic pbit, input int nstop, input logic stop_val,
                            input int glitch_bit);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < len; i++) send_bit(data[i], i == glitch_bit);
    if (par_en) send_bit(pbit, 1'b0);
    for (int i = 0; i < nstop; i++) send_bit(stop_val, 1'b0);
  endtask

  task automatic watch_no_valid(input string name, input int ticks);
    int v = 0;
    repeat (ticks) begin
      @(negedge clk_16bd);
      #1;
      if (frame_valid) v++;
    end
    check(name, v, 0);
  endtask

  // Monitor: compares each accepted frame against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_16bd);
      #1;
      if (overrun) ovr_cnt++;
      if (frame_valid && frame_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_frame: got frame 0x%0h, expected no frame", frame);
        end else begin
          e = sb.pop_front();
          check("frame", 32'(frame), 32'(e.data));
          check("parity_err", 32'(parity_err), 32'(e.perr));
          check("frame_err", 32'(frame_err), 32'(e.ferr));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Rx = 1'b1;
    rst = 1'b1;
    frame_ready = 1'b1;
    set_cfg(1'b0, 1'b0, 1'b0, 4'd8);
    repeat (3) @(negedge clk_16bd);
    check("rst_frame", 32'(frame), 0);
    check("rst_valid", 32'(frame_valid), 0);
    check("rst_perr", 32'(parity_err), 0);
    check("rst_ferr", 32'(frame_err), 0);
    check("rst_overrun", 32'(overrun), 0);
    rst = 1'b0;
    idle(20);

    // 8N1 0xA5: valid rises 3 sync/detect ticks + 154 ticks after the Rx fall.
    push(9'h0A5, 1'b0, 1'b0);
    fork
      send_frame(9'h0A5, 8, 0, 1'b0, 1, 1'b1, -1);
      begin
        int n = 0;
        do begin
          @(negedge clk_16bd);
          #1;
          n++;
        end while (!frame_valid && n < 400);
        check("latency_8n1", n, 157);
      end
    join
    idle(20);
    check("drain_8n1", sb.size(), 0);

    // 9 data bits, odd parity, 2 stop bits; 7E1 for the even encoding.
    set_cfg(1'b1, 1'b1, 1'b1, 4'd9);
    push(9'h1FF, 1'b0, 1'b0);
    send_frame(9'h1FF, 9, 1, 1'b0, 2, 1'b1, -1);
    idle(10);
    push(9'h1FF, 1'b1, 1'b0);
    send_frame(9'h1FF, 9, 1, 1'b1, 2, 1'b1, -1);
    idle(10);
    set_cfg(1'b1, 1'b0, 1'b0, 4'd7);
    push(9'h041, 1'b0, 1'b0);
    send_frame(9'h041, 7, 1, 1'b0, 1, 1'b1, -1);
    idle(20);
    check("drain_parity", sb.size(), 0);

    // False start: a 4-tick low pulse must not produce a frame.
    set_cfg(1'b0, 1'b0, 1'b0, 4'd8);
    Rx = 1'b0;
    repeat (4) @(negedge clk_16bd);
    Rx = 1'b1;
    watch_no_valid("false_start", 200);
    idle(10);

    // Single-tick glitches at mid-bit on a 1 and on a 0 data bit.
    push(9'h03C, 1'b0, 1'b0);
    send_frame(9'h03C, 8, 0, 1'b0, 1, 1'b1, 2);
    idle(10);
    push(9'h03C, 1'b0, 1'b0);
    send_frame(9'h03C, 8, 0, 1'b0, 1, 1'b1, 6);
    idle(20);
    check("drain_glitch", sb.size(), 0);

    // Low stop bit, then the line held low: only the one errored frame.
    push(9'h055, 1'b0, 1'b1);
    send_frame(9'h055, 8, 0, 1'b0, 1, 1'b0, -1);
    watch_no_valid("held_low", 200);
    Rx = 1'b1;
    watch_no_valid("released_high", 64);
    check("drain_ferr", sb.size(), 0);
    push(9'h05A, 1'b0, 1'b0);
    send_frame(9'h05A, 8, 0, 1'b0, 1, 1'b1, -1);
    idle(20);
    check("drain_after_low", sb.size(), 0);

    // Overrun: ready low, 0x11 then 0x22 back to back.
    frame_ready = 1'b0;
    push(9'h011, 1'b0, 1'b0);
    send_frame(9'h011, 8, 0, 1'b0, 1, 1'b1, -1);
    send_frame(9'h022, 8, 0, 1'b0, 1, 1'b1, -1);
    idle(8);
    check("overrun_hold_frame", 32'(frame), 32'h011);
    check("overrun_hold_valid", 32'(frame_valid), 1);
    check("overrun_count", ovr_cnt, 1);
    // Ready raised exactly in the delivery cycle of 0x33: swap, no overrun.
    push(9'h033, 1'b0, 1'b0);
    fork
      send_frame(9'h033, 8, 0, 1'b0, 1, 1'b1, -1);
      begin
        repeat (156) @(negedge clk_16bd);
        frame_ready = 1'b1;
      end
    join
    idle(20);
    check("overrun_after_swap", ovr_cnt, 1);
    check("drain_overrun", sb.size(), 0);

    // Length clamp: 3 behaves as 5, 12 behaves as 9.
    set_cfg(1'b0, 1'b0, 1'b0, 4'd3);
    push(9'h015, 1'b0, 1'b0);
    send_frame(9'h015, 5, 0, 1'b0, 1, 1'b1, -1);
    idle(10);
    set_cfg(1'b0, 1'b0, 1'b0, 4'd12);
    push(9'h12B, 1'b0, 1'b0);
    send_frame(9'h12B, 9, 0, 1'b0, 1, 1'b1, -1);
    idle(20);
    check("drain_clamp", sb.size(), 0);

    // Reset in DATA with a frame held: everything clears, next frame is clean.
    set_cfg(1'b0, 1'b0, 1'b0, 4'd8);
    frame_ready = 1'b0;
    send_frame(9'h05A, 8, 0, 1'b0, 1, 1'b1, -1);
    idle(4);
    check("pre_rst_frame", 32'(frame), 32'h05A);
    Rx = 1'b0;
    repeat (OS) @(negedge clk_16bd);
    Rx = 1'b1;
    repeat (40) @(negedge clk_16bd);
    rst = 1'b1;
    @(negedge clk_16bd);
    check("midrst_frame", 32'(frame), 0);
    check("midrst_valid", 32'(frame_valid), 0);
    check("midrst_perr", 32'(parity_err), 0);
    check("midrst_ferr", 32'(frame_err), 0);
    check("midrst_overrun", 32'(overrun), 0);
    rst = 1'b0;
    frame_ready = 1'b1;
    idle(40);
    push(9'h0C3, 1'b0, 1'b0);
    send_frame(9'h0C3, 8, 0, 1'b0, 1, 1'b1, -1);
    idle(20);
    check("drain_after_rst", sb.size(), 0);
    check("overrun_total", ovr_cnt, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
